apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
- APB4 completer (responder) exposing NUM_REGS word-wide read/write registers to one demux output port.
- Inserts a fixed, programmable number of wait states.
- Flags out-of-range and misaligned accesses with PSLVERR.
- Mirrors all register contents to the fabric on a flat output bus.
- Serves as the standard endpoint behind the APB demux and as the bench responder for demux verification.

Parameters:
ADDR_WIDTH, 8, width of PADDR (byte address)
DATA_WIDTH, 32, width of PWDATA/PRDATA; must be 32
NUM_REGS, 8, number of 32-bit registers at byte offsets 0x00, 0x04, ... up to 4*(NUM_REGS-1)
WAIT_STATES, 1, PREADY-low access cycles before completion; 0..15

Ports:
PCLK  input  1  clock; all logic on rising edge
PRESET  input  1  synchronous active-high reset
PSELx  input  1  select from demux
PENABLE  input  1  access-phase indicator
PWRITE  input  1  1 = write, 0 = read
PADDR  input  ADDR_WIDTH  byte address
PWDATA  input  DATA_WIDTH  write data
PSTRB  input  DATA_WIDTH/8  byte-lane write strobes
PRDATA  output  DATA_WIDTH  read data; valid only while PREADY=1
PREADY  output  1  transfer completion
PSLVERR  output  1  error response; valid only while PREADY=1
regs_flat  output  NUM_REGS*DATA_WIDTH  register i at bits [32*i +: 32]

Behaviour:
- Reset (PRESET=1 at a rising edge) has priority over everything. It forces:
  - state IDLE, wait counter 0
  - PREADY=0, PSLVERR=0, PRDATA=0
  - all registers 0
  - Reset mid-transfer aborts the transfer and commits no write.
- PREADY, PSLVERR and PRDATA are registered outputs.
- Address decode:
  - idx = PADDR >> 2.
  - err = (PADDR[1:0] != 0) or (idx >= NUM_REGS).
  - Decode is evaluated in the SETUP cycle and latched together with PWRITE, PWDATA and PSTRB.
- FSM states:
  - IDLE: on PSELx=1 & PENABLE=0, latch the request, load counter=WAIT_STATES, go to ACCESS.
  - ACCESS: PREADY=0 while counter>0; counter decrements each cycle that PSELx & PENABLE.
    - When the counter reaches 0, drive PREADY=1 for exactly one cycle. For WAIT_STATES=0 this is the first PENABLE cycle.
    - Then go to IDLE.
- Latency: a transfer occupies 2+WAIT_STATES cycles (SETUP + WAIT_STATES wait cycles + 1 completion cycle).
- Back-to-back transfers: SETUP may follow the completion cycle immediately; no idle cycle is required.
- Write commit:
  - Happens at the rising edge ending the PREADY=1 cycle, only if err=0.
  - Byte lane b is updated only when PSTRB[b]=1.
  - PSTRB=0 produces a legal transfer with no change.
- Read: in the PREADY=1 cycle, PRDATA = register[idx] if err=0, else 0. At all other times PRDATA=0.
- Error:
  - PSLVERR = err, asserted only in the PREADY=1 cycle; 0 otherwise.
  - An errored write changes nothing.
- Protocol violations:
  - PSELx drops in ACCESS before completion: abort to IDLE, no commit, PREADY stays 0.
  - PENABLE=1 in IDLE without a prior SETUP: ignored.
  - PENABLE low while in ACCESS: counter holds.
  - Address or data changing during ACCESS is ignored; the latched values are used.
- regs_flat reflects register state continuously. A write becomes visible on regs_flat the cycle after PREADY.

Test Plan:
1. WAIT_STATES=1; after reset, write 0xDEADBEEF to 0x04, PSTRB=4'hF.
   - PREADY high on the 2nd PENABLE cycle; PSLVERR=0.
   - regs_flat[63:32]=0xDEADBEEF next cycle.
   - Read 0x04 -> PRDATA=0xDEADBEEF in the PREADY cycle.
2. Partial write: PSTRB=4'b0101, PWDATA=0x11223344 to 0x04 (holding 0xDEADBEEF).
   - Read back 0xDE22BE44.
3. Errors:
   - Write 0x20 (idx 8 >= NUM_REGS) -> PSLVERR=1 with PREADY, no register changes.
   - Read 0x06 (misaligned) -> PSLVERR=1, PRDATA=0.
4. WAIT_STATES=0, back-to-back:
   - Write 0xA5A5A5A5 to 0x00 then immediately read 0x00 -> each transfer 2 cycles, PRDATA=0xA5A5A5A5.
   - WAIT_STATES=3 -> PREADY asserts on the 4th PENABLE cycle.
5. Abort: WAIT_STATES=2, write 0x12345678 to 0x08, drop PSELx after 1 PENABLE cycle.
   - PREADY never asserts; reg2 stays 0.
   - The next SETUP is accepted normally.
6. Reset mid-transfer: assert PRESET during ACCESS of a write to 0x0C.
   - PREADY=0, PSLVERR=0, PRDATA=0, and all regs_flat=0 the cycle after the reset edge.
   - No commit occurs.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB4 completer with NUM_REGS byte-strobed registers, fixed wait states and PSLVERR on bad addresses.
// Outputs are registered; a transfer takes 2+WAIT_STATES cycles, and all register contents are mirrored on regs_flat.
module apb_slave_regfile #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic                           PSELx,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

  localparam int          IDXW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int          NB         = DATA_WIDTH / 8;
  localparam logic [3:0]  WS         = WAIT_STATES[3:0];
  localparam logic [31:0] NUM_REGS_U = NUM_REGS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic                  req_write;
  logic                  req_err;
  logic [IDXW-1:0]       req_idx;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [NB-1:0]         req_strb;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [ADDR_WIDTH-3:0] addr_word;
  logic                  dec_err;
  logic [IDXW-1:0]       dec_idx;
  logic                  setup;

  logic                  rsp_write;
  logic                  rsp_err;
  logic [IDXW-1:0]       rsp_idx;
  logic                  rdy_nxt;
  logic                  err_nxt;
  logic [DATA_WIDTH-1:0] rdata_nxt;
  logic                  commit;

  assign addr_word = PADDR[ADDR_WIDTH-1:2];
  assign dec_err   = (PADDR[1:0] != 2'b00) || (32'(addr_word) >= NUM_REGS_U);
  assign dec_idx   = addr_word[IDXW-1:0];
  assign setup     = PSELx && !PENABLE;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        // PENABLE already high here means no SETUP phase was seen; not a request.
        if (setup) begin
          cnt_nxt   = WS;
          state_nxt = (WS == 4'd0) ? COMPLETE : ACCESS;
        end
      end
      ACCESS: begin
        if (!PSELx) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (PENABLE) begin
          cnt_nxt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
          if (cnt <= 4'd1) begin
            state_nxt = COMPLETE;
          end
        end
      end
      COMPLETE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Request is captured in the SETUP cycle; later bus changes are ignored.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      req_write <= 1'b0;
      req_err   <= 1'b0;
      req_idx   <= '0;
      req_wdata <= '0;
      req_strb  <= '0;
    end else if (state == IDLE && setup) begin
      req_write <= PWRITE;
      req_err   <= dec_err;
      req_idx   <= dec_idx;
      req_wdata <= PWDATA;
      req_strb  <= PSTRB;
    end
  end

  // With zero wait states COMPLETE is entered straight from IDLE, so the live decode is used.
  always_comb begin
    rsp_write = req_write;
    rsp_err   = req_err;
    rsp_idx   = req_idx;
    if (state == IDLE) begin
      rsp_write = PWRITE;
      rsp_err   = dec_err;
      rsp_idx   = dec_idx;
    end
    rdy_nxt   = (state_nxt == COMPLETE);
    err_nxt   = rdy_nxt && rsp_err;
    rdata_nxt = '0;
    if (rdy_nxt && !rsp_err && !rsp_write) begin
      rdata_nxt = regs[rsp_idx];
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      PREADY  <= rdy_nxt;
      PSLVERR <= err_nxt;
      PRDATA  <= rdata_nxt;
    end
  end

  assign commit = (state == COMPLETE) && req_write && !req_err;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (32'(req_idx) == i) begin
          for (int b = 0; b < NB; b++) begin
            if (req_strb[b]) begin
              regs[i][8*b +: 8] <= req_wdata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Four completers with WAIT_STATES 0..3 on one clock, checked against an array model of the register file.
module tb_apb_slave_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel   [4];
  logic        pen    [4];
  logic        pwr    [4];
  logic [7:0]  paddr  [4];
  logic [31:0] pwdata [4];
  logic [3:0]  pstrb  [4];
  logic [31:0] prdata [4];
  logic        pready [4];
  logic        pslverr[4];
  logic [255:0] flat  [4];

  logic [31:0] mreg [4][8];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    apb_slave_regfile #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (32),
      .NUM_REGS   (8),
      .WAIT_STATES(g)
    ) u_dut (
      .PCLK     (clk),
      .PRESET   (rst),
      .PSELx    (psel[g]),
      .PENABLE  (pen[g]),
      .PWRITE   (pwr[g]),
      .PADDR    (paddr[g]),
      .PWDATA   (pwdata[g]),
      .PSTRB    (pstrb[g]),
      .PRDATA   (prdata[g]),
      .PREADY   (pready[g]),
      .PSLVERR  (pslverr[g]),
      .regs_flat(flat[g])
    );
  end

  function automatic logic model_err(input logic [7:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 8'd8);
  endfunction

  function automatic logic [255:0] model_flat(input int d);
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[32*i +: 32] = mreg[d][i];
    return f;
  endfunction

  task automatic model_write(input int d, input logic [7:0] a, input logic [31:0] wd, input logic [3:0] st);
    if (!model_err(a)) begin
      for (int b = 0; b < 4; b++)
        if (st[b]) mreg[d][a >> 2][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 8; i++) mreg[d][i] = '0;
  endtask

  task automatic bus_idle(input int d);
    psel[d] = 1'b0;
    pen[d]  = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge after the completion cycle.
  task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input bit stall, output logic [31:0] rd,
                      output logic er, output int pen_cycles, output bit leak);
    bit done = 0;
    psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr;
    paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
    pen_cycles = 0; leak = 0; rd = '0; er = 1'b0;
    @(negedge clk);
    for (int guard = 0; guard < 64 && !done; guard++) begin
      if (pready[d] === 1'b1) begin
        pen[d] = 1'b1;
        pen_cycles++;
        rd = prdata[d];
        er = pslverr[d];
        done = 1;
      end else begin
        if (prdata[d] !== 32'd0 || pslverr[d] !== 1'b0) leak = 1;
        if (stall && pen_cycles > 0 && $urandom_range(0, 2) == 0) begin
          pen[d] = 1'b0;
        end else begin
          pen[d] = 1'b1;
          pen_cycles++;
        end
        if (stall) begin
          paddr[d]  = 8'($urandom);
          pwdata[d] = $urandom;
          pwr[d]    = 1'($urandom);
        end
        @(negedge clk);
      end
    end
    if (!done) pen_cycles = -1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 4; d++) bus_idle(d);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      total++;
      if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || prdata[d] !== 32'd0) begin
        bad++;
        $display("FAIL reset_outputs[%0d]: got rdy=%b err=%b rdata=%h want 0 0 0", d, pready[d], pslverr[d], prdata[d]);
      end
      total++;
      if (flat[d] !== 256'd0) begin
        bad++;
        $display("FAIL reset_regs[%0d]: got %h want 0", d, flat[d]);
      end
    end
    rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic er; int n; bit lk;
    xfer(1, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 0, rd, er, n, lk);
    model_write(1, 8'h04, 32'hDEADBEEF, 4'hF);
    total++;
    if (n !== 2 || er !== 1'b0) begin
      bad++;
      $display("FAIL basic_write_rsp: got pen_cycles=%0d err=%b want 2 0", n, er);
    end
    total++;
    if (flat[1][63:32] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL basic_flat: got %h want deadbeef", flat[1][63:32]);
    end
    xfer(1, 1'b0, 8'h04, 32'h0, 4'h0, 0, rd, er, n, lk);
    total++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || n !== 2 || lk) begin
      bad++;
      $display("FAIL basic_read: got rdata=%h err=%b cycles=%0d leak=%b want deadbeef 0 2 0", rd, er, n, lk);
    end
    bus_idle(1);
    @(negedge clk);
  endtask

  task automatic test_partial();
    logic [31:0] rd; logic er; int n; bit lk;
    xfer(1, 1'b1, 8'h04, 32'h11223344, 4'b0101, 0, rd, er, n, lk);
    model_write(1, 8'h04, 32'h11223344, 4'b0101);
    xfer(1, 1'b0, 8'h04, 32'h0, 4'h0, 0, rd, er, n, lk);
    total++;
    if (rd !== 32'hDE22BE44 || er !== 1'b0) begin
      bad++;
      $display("FAIL partial_read: got %h err=%b want de22be44 0", rd, er);
    end
    bus_idle(1);
    @(negedge clk);
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int n; bit lk;
    xfer(1, 1'b1, 8'h20, 32'hFFFFFFFF, 4'hF, 0, rd, er, n, lk);
    total++;
    if (er !== 1'b1 || n !== 2) begin
      bad++;
      $display("FAIL err_oob_write: got err=%b cycles=%0d want 1 2", er, n);
    end
    total++;
    if (flat[1] !== model_flat(1)) begin
      bad++;
      $display("FAIL err_oob_nochange: got %h want %h", flat[1], model_flat(1));
    end
    xfer(1, 1'b0, 8'h06, 32'h0, 4'h0, 0, rd, er, n, lk);
    total++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      bad++;
      $display("FAIL err_misaligned_read: got err=%b rdata=%h want 1 0", er, rd);
    end
    bus_idle(1);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int n1, n2; bit lk; int c0;
    c0 = cyc;
    xfer(0, 1'b1, 8'h00, 32'hA5A5A5A5, 4'hF, 0, rd, er, n1, lk);
    model_write(0, 8'h00, 32'hA5A5A5A5, 4'hF);
    xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, 0, rd, er, n2, lk);
    total++;
    if (cyc - c0 !== 4 || n1 !== 1 || n2 !== 1) begin
      bad++;
      $display("FAIL b2b_timing: got cycles=%0d pen=%0d/%0d want 4 1/1", cyc - c0, n1, n2);
    end
    total++;
    if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin
      bad++;
      $display("FAIL b2b_read: got %h err=%b want a5a5a5a5 0", rd, er);
    end
    bus_idle(0);
    xfer(3, 1'b1, 8'h10, 32'h0BADF00D, 4'hF, 0, rd, er, n1, lk);
    model_write(3, 8'h10, 32'h0BADF00D, 4'hF);
    total++;
    if (n1 !== 4 || flat[3][159:128] !== 32'h0BADF00D) begin
      bad++;
      $display("FAIL ws3_write: got pen_cycles=%0d reg4=%h want 4 0badf00d", n1, flat[3][159:128]);
    end
    bus_idle(3);
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int n; bit lk; bit seen = 0;
    psel[2] = 1'b1; pen[2] = 1'b0; pwr[2] = 1'b1;
    paddr[2] = 8'h08; pwdata[2] = 32'h12345678; pstrb[2] = 4'hF;
    @(negedge clk);
    pen[2] = 1'b1;
    @(negedge clk);
    bus_idle(2);
    for (int i = 0; i < 4; i++) begin
      if (pready[2] !== 1'b0) seen = 1;
      @(negedge clk);
    end
    // PENABLE without SETUP must not start a transfer.
    psel[2] = 1'b1; pen[2] = 1'b1; paddr[2] = 8'h08;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (pready[2] !== 1'b0) seen = 1;
    end
    bus_idle(2);
    @(negedge clk);
    total++;
    if (seen) begin
      bad++;
      $display("FAIL abort_pready: got PREADY=1 during abort/stray PENABLE, want 0");
    end
    total++;
    if (flat[2][95:64] !== 32'd0) begin
      bad++;
      $display("FAIL abort_nocommit: got reg2=%h want 0", flat[2][95:64]);
    end
    xfer(2, 1'b0, 8'h08, 32'h0, 4'h0, 0, rd, er, n, lk);
    total++;
    if (n !== 3 || rd !== 32'd0 || er !== 1'b0) begin
      bad++;
      $display("FAIL abort_next_setup: got cycles=%0d rdata=%h err=%b want 3 0 0", n, rd, er);
    end
    bus_idle(2);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, wd; logic er, wr; int n; bit lk, stall; int d;
    logic [7:0] a; logic [3:0] st;
    for (int it = 0; it < 80; it++) begin
      d = $urandom_range(0, 3);
      for (int o = 0; o < 4; o++) if (o != d) bus_idle(o);
      wr = 1'($urandom);
      a = 8'($urandom_range(0, 35));
      wd = $urandom;
      st = 4'($urandom);
      stall = 1'($urandom);
      exp_rd = model_err(a) ? 32'd0 : mreg[d][a >> 2];
      xfer(d, wr, a, wd, st, stall, rd, er, n, lk);
      if (wr) model_write(d, a, wd, st);
      total++;
      if (n !== d + 1 || er !== model_err(a) || lk) begin
        bad++;
        $display("FAIL rand_rsp[%0d]: inst=%0d addr=%h got cycles=%0d err=%b leak=%b want %0d %b 0",
                 it, d, a, n, er, lk, d + 1, model_err(a));
      end
      if (!wr) begin
        total++;
        if (rd !== exp_rd) begin
          bad++;
          $display("FAIL rand_read[%0d]: inst=%0d addr=%h got %h want %h", it, d, a, rd, exp_rd);
        end
      end
      total++;
      if (flat[d] !== model_flat(d)) begin
        bad++;
        $display("FAIL rand_regs[%0d]: inst=%0d got %h want %h", it, d, flat[d], model_flat(d));
      end
      if ($urandom_range(0, 1) == 1) begin
        bus_idle(d);
        @(negedge clk);
      end
    end
    for (int o = 0; o < 4; o++) bus_idle(o);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int n; bit lk;
    xfer(3, 1'b1, 8'h00, 32'h55AA55AA, 4'hF, 0, rd, er, n, lk);
    bus_idle(3);
    @(negedge clk);
    psel[3] = 1'b1; pen[3] = 1'b0; pwr[3] = 1'b1;
    paddr[3] = 8'h0C; pwdata[3] = 32'hCAFEF00D; pstrb[3] = 4'hF;
    @(negedge clk);
    pen[3] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (pready[3] !== 1'b0 || pslverr[3] !== 1'b0 || prdata[3] !== 32'd0) begin
      bad++;
      $display("FAIL midreset_outputs: got rdy=%b err=%b rdata=%h want 0 0 0", pready[3], pslverr[3], prdata[3]);
    end
    for (int d = 0; d < 4; d++) begin
      total++;
      if (flat[d] !== 256'd0) begin
        bad++;
        $display("FAIL midreset_regs[%0d]: got %h want 0", d, flat[d]);
      end
    end
    rst = 1'b0;
    bus_idle(3);
    model_clear();
    repeat (3) @(negedge clk);
    total++;
    if (flat[3] !== 256'd0) begin
      bad++;
      $display("FAIL midreset_nocommit: got %h want 0", flat[3]);
    end
    xfer(3, 1'b0, 8'h0C, 32'h0, 4'h0, 0, rd, er, n, lk);
    total++;
    if (rd !== 32'd0 || er !== 1'b0 || n !== 4) begin
      bad++;
      $display("FAIL midreset_readback: got rdata=%h err=%b cycles=%0d want 0 0 4", rd, er, n);
    end
    bus_idle(3);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 4; d++) begin
      bus_idle(d);
      pwr[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
    end
    model_clear();
    @(negedge clk);
    test_reset();
    test_basic();
    test_partial();
    test_errors();
    test_back_to_back();
    test_abort();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
